// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and the colour-bar table for the VGA raster engine.
package vga_pkg;

    localparam int unsigned VGA_CLK_DIV  = 2;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_READ_LAT = 2;
    localparam int unsigned NUM_BARS     = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_BLACK = 2'd2,
        MODE_RSVD  = 2'd3
    } vga_mode_e;

    // Per-pixel raster attributes carried down the fetch-latency pipeline.
    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic [2:0] bar;
    } raster_t;

    // White, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
            3'd1:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
            3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
            3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
            3'd4:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
            3'd5:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
            3'd6:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
            default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pix_en_gen.sv
// Pixel-rate enable generator.
//   clk, reset : system clock, async active-high reset
//   pix_en     : one-clk strobe on the last clk of each pixel period
//   vga_clk    : DAC clock, high for the first CLK_DIV/2 clks of each pixel period
module pix_en_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en,
    output logic vga_clk
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end

    // pix_en and vga_clk are registered copies of decodes of the next divider value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
            vga_clk <= 1'b1;
        end else begin
            div_cnt <= div_next;
            pix_en  <= (div_next == DIV_LAST);
            vga_clk <= (div_next < DIV_HALF);
        end
    end

endmodule

// File: rtl/vga_timing_engine.sv
// VGA raster engine: H/V counters, pixel fetch requests, latency-aligned sync/blank/colour to the DAC.
//   clk, reset              : system clock, async active-high reset
//   mode                    : 0 external, 1 colour bars, 2/3 black; latched at frame start
//   pix_req, pix_x, pix_y   : fetch strobe and coordinate for each active pixel
//   pix_rgb                 : fetched {R,G,B}, sampled READ_LAT pixel ticks after pix_req
//   frame_start             : one-clk pulse on the pixel tick at h = v = 0
//   VGA_R/G/B, VGA_HS/VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK : DAC pins
module vga_timing_engine
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned READ_LAT = VGA_READ_LAT,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     mode,
    output logic           pix_req,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    input  logic [23:0]    pix_rgb,
    output logic           frame_start,
    output logic [7:0]     VGA_R,
    output logic [7:0]     VGA_G,
    output logic [7:0]     VGA_B,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           VGA_BLANK_N,
    output logic           VGA_SYNC_N,
    output logic           VGA_CLK
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HC_W    = $clog2(H_TOTAL);
    localparam int unsigned VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT_LAST = HC_W'(H_ACTIVE - 1);
    localparam logic [HC_W-1:0] HS_FIRST   = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_LAST    = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_LAST = VC_W'(V_ACTIVE - 1);
    localparam logic [VC_W-1:0] VS_FIRST   = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_LAST    = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [HC_W-1:0] BAR_LAST   = HC_W'(H_ACTIVE / NUM_BARS - 1);
    localparam logic [2:0]      BAR_MAX    = 3'(NUM_BARS - 1);

    logic            pix_en;
    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;
    logic [HC_W-1:0] bar_px;
    logic [2:0]      bar_idx;
    logic            at_origin;
    raster_t         cur;
    raster_t         pipe [READ_LAT];
    raster_t         pipe_out;
    vga_mode_e       mode_q;
    rgb_t            rgb_next;
    rgb_t            rgb_q;

    pix_en_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en_gen (
        .clk     (clk),
        .reset   (reset),
        .pix_en  (pix_en),
        .vga_clk (VGA_CLK)
    );

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    // Raster counters; a line wrap on the last line also wraps the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VC_W'(1);
            end else begin
                h_cnt <= h_cnt + HC_W'(1);
            end
        end
    end

    // Bar index tracks h without a divider; the last bar absorbs any remainder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if ((h_cnt <= H_ACT_LAST) && (bar_idx != BAR_MAX)) begin
                if (bar_px == BAR_LAST) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + HC_W'(1);
                end
            end
        end
    end

    always_comb begin
        cur        = '0;
        cur.active = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
        cur.hs     = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        cur.vs     = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        cur.bar    = bar_idx;
    end

    // Stage 0: fetch request, frame marker and mode latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            mode_q      <= MODE_EXT;
        end else begin
            pix_req     <= pix_en && cur.active;
            frame_start <= pix_en && at_origin;
            if (pix_en && cur.active) begin
                pix_x <= X_W'(h_cnt);
                pix_y <= Y_W'(v_cnt);
            end
            if (pix_en && at_origin) begin
                mode_q <= vga_mode_e'(mode);
            end
        end
    end

    // Delay raster attributes to line up with the returning pixel data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else if (pix_en) begin
            pipe[0] <= cur;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign pipe_out = pipe[READ_LAT-1];

    always_comb begin
        rgb_next = '0;
        if (pipe_out.active) begin
            case (mode_q)
                MODE_EXT:  rgb_next = rgb_t'(pix_rgb);
                MODE_BARS: rgb_next = bar_colour(pipe_out.bar);
                default:   rgb_next = '0;
            endcase
        end
    end

    // DAC output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q       <= '0;
            VGA_BLANK_N <= 1'b0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
        end else if (pix_en) begin
            rgb_q       <= rgb_next;
            VGA_BLANK_N <= pipe_out.active;
            VGA_HS      <= pipe_out.hs ? HS_POL : ~HS_POL;
            VGA_VS      <= pipe_out.vs ? VS_POL : ~VS_POL;
        end
    end

    assign VGA_R      = rgb_q.r;
    assign VGA_G      = rgb_q.g;
    assign VGA_B      = rgb_q.b;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Self-checking bench for vga_timing_engine on a miniature 8x4 raster.
module tb_vga_timing_engine;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned H_ACTIVE   = 8;
    localparam int unsigned H_FP       = 1;
    localparam int unsigned H_SYNC     = 2;
    localparam int unsigned H_BP       = 1;
    localparam int unsigned V_ACTIVE   = 4;
    localparam int unsigned V_FP       = 1;
    localparam int unsigned V_SYNC     = 1;
    localparam int unsigned V_BP       = 1;
    localparam int unsigned READ_LAT   = 2;
    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam int unsigned SRC_D      = READ_LAT * CLK_DIV;
    localparam int unsigned BAR_W      = H_ACTIVE / 8;

    typedef struct packed {
        logic        blank_n;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } dac_t;

    localparam dac_t DAC_IDLE = {1'b0, 1'b1, 1'b1, 24'h000000};

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        frame_start;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    int   checks = 0;
    int   errors = 0;
    int   c;
    int   req_cnt;
    int   phase, p, h, v;
    bit   act;
    logic exp_fs, exp_req;
    logic rst_s, mode_chg;
    logic [1:0]  mode_s;
    logic [1:0]  frame_mode;
    dac_t        rec;
    dac_t        cur_exp;
    dac_t        exp_q [$];
    logic [23:0] src_d [SRC_D];

    always #5 clk = ~clk;

    vga_timing_engine #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (1'b0), .VS_POL (1'b0),
        .READ_LAT (READ_LAT), .X_W (10), .Y_W (10)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .mode        (mode),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .VGA_BLANK_N (vga_blank_n),
        .VGA_SYNC_N  (vga_sync_n),
        .VGA_CLK     (vga_clk)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Test pattern returned by the frame-store model for pixel (x, y).
    function automatic logic [23:0] src_pix(input int x, input int y);
        return {8'h40 | 8'(y), 8'(x), 8'h3C ^ 8'(x)};
    endfunction

    function automatic logic [23:0] bar_rgb(input int x);
        int b;
        b = x / BAR_W;
        if (b > 7) b = 7;
        case (b)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_dac"}, {vga_blank_n, vga_hs, vga_vs, vga_r, vga_g, vga_b}, DAC_IDLE);
        check_eq({tag, "_pix_req"}, pix_req, 1'b0);
        check_eq({tag, "_frame_start"}, frame_start, 1'b0);
        check_eq({tag, "_vga_clk"}, vga_clk, 1'b1);
        check_eq({tag, "_sync_n"}, vga_sync_n, 1'b0);
    endtask

    // Waits (bounded) until the bench cycle count reaches the given phase within a frame.
    task automatic wait_phase(input int ph);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
            @(negedge clk);
            #1;
            if (c % FRAME_CLKS == ph) found = 1'b1;
        end
        if (!found) check_eq("wait_phase_timeout", 32'd0, 32'd1);
    endtask

    always @(posedge clk) begin
        rst_s  <= rst;
        mode_s <= mode;
    end

    // Reference raster, frame-store source model and scoreboard.
    always @(negedge clk) begin
        if (rst || rst_s) begin
            c          = 0;
            req_cnt    = 0;
            frame_mode = 2'd0;
            cur_exp    = DAC_IDLE;
            exp_q.delete();
            for (int i = 0; i < READ_LAT; i++) exp_q.push_back(DAC_IDLE);
            for (int i = 0; i < SRC_D; i++) src_d[i] = '0;
            pix_rgb = '0;
        end else begin
            c++;
            for (int i = SRC_D - 1; i > 0; i--) src_d[i] = src_d[i-1];
            src_d[0] = pix_req ? src_pix(int'(pix_x), int'(pix_y)) : 24'($urandom);
            pix_rgb  = src_d[SRC_D-1];

            phase   = c % CLK_DIV;
            exp_fs  = 1'b0;
            exp_req = 1'b0;
            if (phase == 0) begin
                p   = c / CLK_DIV - 1;
                h   = p % H_TOTAL;
                v   = (p / H_TOTAL) % V_TOTAL;
                act = (h < H_ACTIVE) && (v < V_ACTIVE);
                if (h == 0 && v == 0) begin
                    frame_mode = mode_s;
                    exp_fs     = 1'b1;
                    if (p > 0) begin
                        check_eq("req_per_frame", req_cnt, 32'd32);
                        req_cnt = 0;
                    end
                end
                exp_req     = act;
                rec.blank_n = act;
                rec.hs      = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
                rec.vs      = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
                if (!act)                 rec.rgb = 24'h0;
                else if (frame_mode == 0) rec.rgb = src_pix(h, v);
                else if (frame_mode == 1) rec.rgb = bar_rgb(h);
                else                      rec.rgb = 24'h0;
                exp_q.push_back(rec);
                cur_exp = exp_q.pop_front();
            end
            if (pix_req) req_cnt++;

            check_eq("frame_start", frame_start, exp_fs);
            check_eq("pix_req", pix_req, exp_req);
            if (exp_req) begin
                check_eq("pix_x", pix_x, h);
                check_eq("pix_y", pix_y, v);
            end
            check_eq("vga_clk", vga_clk, (phase < CLK_DIV / 2));
            check_eq("dac", {vga_blank_n, vga_hs, vga_vs, vga_r, vga_g, vga_b}, cur_exp);
        end
    end

    initial begin
        rst  = 1'b1;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3 * FRAME_CLKS) @(negedge clk);

        // Mid-frame switch to bars: rest of this frame stays external.
        wait_phase(80);
        mode = 2'd1;
        repeat (2 * FRAME_CLKS) @(negedge clk);

        wait_phase(40);
        mode = 2'd2;
        repeat (FRAME_CLKS) @(negedge clk);
        mode = 2'd3;
        repeat (FRAME_CLKS + 10) @(negedge clk);
        mode = 2'd1;
        repeat (FRAME_CLKS) @(negedge clk);

        // Asynchronous reset while the counter sits at h = 5, v = 2.
        wait_phase(59);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (2 * FRAME_CLKS) @(negedge clk);

        mode = 2'd0;
        repeat (2 * FRAME_CLKS + 5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
